// File: rtl/riscv_pkg.sv
// Shared core constants for the instruction-fetch stage.
package riscv_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCR = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is the registered oldest entry.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2 * riscv_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, credit-limited imem requests, instruction buffer, redirect flush.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned      XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter int unsigned      BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  logic [XLEN-1:0]   pc, last_pc, rq_head, redirect_target;
  logic [CNT_W-1:0]  inflight, count, drop;
  logic [2*XLEN-1:0] buf_head;
  logic              req_fire, rsp_keep, id_fire;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign imem_req_valid  = rst_n & ~redirect_valid
                         & ((32'(inflight) + 32'(count)) < BUF_DEPTH);
  assign imem_req_addr   = pc;
  assign req_fire        = imem_req_valid & imem_req_ready;
  assign rsp_keep        = imem_rsp_valid & ~redirect_valid & (drop == '0);
  assign id_fire         = id_valid & id_ready & ~redirect_valid;

  // The request-address queue occupancy doubles as the in-flight count.
  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(XLEN)) u_addr_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .pop   (imem_rsp_valid),
    .flush (1'b0),
    .wdata (pc),
    .count (inflight),
    .head  (rq_head)
  );

  fetch_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(2 * XLEN)) u_ibuf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_keep),
    .pop   (id_fire),
    .flush (redirect_valid),
    .wdata ({imem_rsp_data, rq_head}),
    .count (count),
    .head  (buf_head)
  );

  assign id_valid = (count != '0);
  assign id_instr = id_valid ? buf_head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
  assign id_pc    = id_valid ? buf_head[XLEN-1:0] : last_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      drop    <= '0;
      last_pc <= RESET_PC;
    end else begin
      if (redirect_valid)  pc <= redirect_target;
      else if (req_fire)   pc <= pc + XLEN'(PC_INCR);

      // Every unanswered request becomes stale; drop never exceeds inflight.
      if (redirect_valid)
        drop <= inflight - CNT_W'(imem_rsp_valid);
      else if (imem_rsp_valid && drop != '0)
        drop <= drop - CNT_W'(1);

      if (id_valid) last_pc <= buf_head[XLEN-1:0];
    end
  end
endmodule
